// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer in front of the single data memory: CPU port
// (byte/half/word) and DMA/debug port (word only), with MEM_LAT wait states per access.
module dmem_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_store_type,
    input  logic [2:0]  cpu_load_type,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_done,
    output logic        dma_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_store_type,
    output logic [2:0]  mem_load_type,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [3:0] LatInit = 4'(MEM_LAT - 1);

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_gnt_q, last_gnt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  st_q, st_d;
    logic [2:0]  lt_q, lt_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;

    logic sel;
    logic misaligned;

    // On a conflict the port that did not win last time gets the grant.
    always_comb begin
        sel = dma_req;
        if (cpu_req && dma_req) begin
            sel = ~last_gnt_q;
        end
    end

    always_comb begin
        misaligned = 1'b0;
        if (sel) begin
            misaligned = |dma_addr[1:0];
        end else if (cpu_we) begin
            case (cpu_store_type)
                2'b01:   misaligned = cpu_addr[0];
                2'b10:   misaligned = |cpu_addr[1:0];
                default: misaligned = 1'b0;
            endcase
        end else begin
            case (cpu_load_type)
                3'b001, 3'b100: misaligned = cpu_addr[0];
                3'b010:         misaligned = |cpu_addr[1:0];
                default:        misaligned = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        last_gnt_d     = last_gnt_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        st_d           = st_q;
        lt_d           = lt_q;
        cpu_rdata_d    = cpu_rdata_q;
        dma_rdata_d    = dma_rdata_q;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_store_type = '0;
        mem_load_type  = '0;
        cpu_done       = 1'b0;
        cpu_err        = 1'b0;
        dma_done       = 1'b0;
        dma_err        = 1'b0;

        case (state_q)
            StIdle: begin
                if (cpu_req || dma_req) begin
                    gnt_d      = sel;
                    last_gnt_d = sel;
                    cnt_d      = LatInit;
                    err_d      = misaligned;
                    we_d       = sel ? dma_we    : cpu_we;
                    addr_d     = sel ? dma_addr  : cpu_addr;
                    wdata_d    = sel ? dma_wdata : cpu_wdata;
                    st_d       = sel ? 2'b10     : cpu_store_type;
                    lt_d       = sel ? 3'b010    : cpu_load_type;
                    state_d    = misaligned ? StResp : StAccess;
                end
            end
            StAccess: begin
                mem_addr       = addr_q;
                mem_wdata      = wdata_q;
                mem_store_type = st_q;
                mem_load_type  = lt_q;
                mem_read       = ~we_q;
                // Stores strobe only in the last wait state so memory sees one write edge.
                mem_write      = we_q && (cnt_q == 4'd0);
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (gnt_q) dma_rdata_d = mem_rdata;
                        else       cpu_rdata_d = mem_rdata;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                cpu_done = ~gnt_q;
                cpu_err  = ~gnt_q & err_q;
                dma_done = gnt_q;
                dma_err  = gnt_q & err_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            gnt_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            cnt_q       <= 4'd0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            st_q        <= '0;
            lt_q        <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            st_q        <= st_d;
            lt_q        <= lt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: byte-addressed data_mem model on the memory side,
// per-port expected-response queues filled at issue and drained by a done monitor.
module tb_dmem_arbiter;

    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [1:0]  cpu_store_type;
    logic [2:0]  cpu_load_type;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_done, cpu_err, cpu_stall, dma_done, dma_err, mem_read, mem_write;
    logic [1:0]  mem_store_type;
    logic [2:0]  mem_load_type;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        cpu_q[$];
    exp_t        dma_q[$];
    bit          order_q[$];
    logic [31:0] last_rd [2];
    logic [7:0]  dmem [512];
    logic [7:0]  rmem [512];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_cnt, rd_cnt, wr_cyc, t_start;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_store_type(cpu_store_type), .cpu_load_type(cpu_load_type),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_done(dma_done), .dma_err(dma_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_store_type(mem_store_type),
        .mem_load_type(mem_load_type), .mem_rdata(mem_rdata)
    );

    // Select and extend a byte/half/word out of an aligned little-endian word.
    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] lt);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        case (lt)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b011:  return {24'd0, s[7:0]};
            3'b100:  return {16'd0, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] dword(input logic [8:0] a);
        logic [8:0] b;
        b = {a[8:2], 2'b00};
        return {dmem[b | 9'd3], dmem[b | 9'd2], dmem[b | 9'd1], dmem[b]};
    endfunction

    assign mem_rdata = extend(dword(mem_addr[8:0]), mem_addr[1:0], mem_load_type);

    always @(posedge clk) begin
        if (mem_write) begin
            dmem[mem_addr[8:0]] = mem_wdata[7:0];
            if (mem_store_type != 2'b00) dmem[mem_addr[8:0] | 9'd1] = mem_wdata[15:8];
            if (mem_store_type == 2'b10) begin
                dmem[mem_addr[8:0] | 9'd2] = mem_wdata[23:16];
                dmem[mem_addr[8:0] | 9'd3] = mem_wdata[31:24];
            end
        end
    end

    // Access size in bytes as log2: 0 byte, 1 half, 2 word.
    function automatic int size_of(input logic we, input logic [1:0] st, input logic [2:0] lt);
        if (we) return (st == 2'b10) ? 2 : (st == 2'b01) ? 1 : 0;
        return (lt == 3'b010) ? 2 : (lt == 3'b001 || lt == 3'b100) ? 1 : 0;
    endfunction

    function automatic void predict(input bit port, input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [1:0] st,
                                    input logic [2:0] lt);
        exp_t e;
        int   sz;
        sz    = size_of(we, st, lt);
        e.err = (addr % (1 << sz)) != 0;
        if (!e.err && we) begin
            for (int i = 0; i < (1 << sz); i++) rmem[addr[8:0] + 9'(i)] = wdata[8*i +: 8];
        end else if (!e.err) begin
            last_rd[port] = extend({rmem[{addr[8:2], 2'd3}], rmem[{addr[8:2], 2'd2}],
                                    rmem[{addr[8:2], 2'd1}], rmem[{addr[8:2], 2'd0}]},
                                   addr[1:0], lt);
        end
        e.rdata = last_rd[port];
        if (port) dma_q.push_back(e);
        else      cpu_q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic txn(input bit port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] st, input logic [2:0] lt,
                       output int lat);
        int start;
        int n;
        predict(port, we, addr, wdata, port ? 2'b10 : st, port ? 3'b010 : lt);
        if (port) begin
            dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
            cpu_store_type = st; cpu_load_type = lt; cpu_req = 1'b1;
        end
        start   = cyc;
        t_start = cyc;
        n       = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? dma_done : cpu_done) && n < 200);
        lat = cyc - start;
        if (!(port ? dma_done : cpu_done)) begin
            checks++;
            errors++;
            $display("FAIL done_timeout port=%0d: no done within 200 cycles", port);
        end
        @(posedge clk);
        #1;
        if (port) dma_req = 1'b0;
        else      cpu_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Done monitor: drains the per-port scoreboards.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (mem_write) begin
                wr_cnt++;
                wr_cyc = cyc;
            end
            if (mem_read) rd_cnt++;
            if (cpu_done) begin
                order_q.push_back(1'b0);
                chk("done_exclusive_c", {31'd0, dma_done}, 32'd0);
                chk("cpu_stall_in_done", {31'd0, cpu_stall}, 32'd0);
                if (cpu_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cpu_unexpected_done: got done, expected none");
                end else begin
                    e = cpu_q.pop_front();
                    chk("cpu_err", {31'd0, cpu_err}, {31'd0, e.err});
                    chk("cpu_rdata", cpu_rdata, e.rdata);
                end
            end
            if (dma_done) begin
                order_q.push_back(1'b1);
                chk("done_exclusive_d", {31'd0, cpu_done}, 32'd0);
                if (cpu_req) chk("cpu_stall_waiting", {31'd0, cpu_stall}, 32'd1);
                if (dma_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dma_unexpected_done: got done, expected none");
                end else begin
                    e = dma_q.pop_front();
                    chk("dma_err", {31'd0, dma_err}, {31'd0, e.err});
                    chk("dma_rdata", dma_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        int lat;
        int g;
        for (int i = 0; i < 512; i++) begin
            dmem[i] = 8'd0;
            rmem[i] = 8'd0;
        end
        last_rd[0] = '0;
        last_rd[1] = '0;
        rst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        cpu_store_type = 0; cpu_load_type = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        wr_cnt = 0; rd_cnt = 0; wr_cyc = 0; t_start = 0;

        // Reset defaults
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {26'd0, cpu_done, dma_done, cpu_err, dma_err, mem_read, mem_write},
            32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dma_rdata", dma_rdata, 32'd0);
        cpu_req = 1'b1;
        #1 chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd1);
        cpu_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("idle_no_mem_activity", 32'(wr_cnt + rd_cnt), 32'd0);

        // SW then LW
        wr_cnt = 0;
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 3'b010, lat);
        chk("sw_latency", 32'(lat), 32'(LAT + 1));
        chk("sw_write_count", 32'(wr_cnt), 32'd1);
        chk("sw_write_cycle", 32'(wr_cyc - t_start), 32'(LAT));
        txn(0, 1'b0, 32'h10, 32'h0, 2'b10, 3'b010, lat);
        chk("lw_latency", 32'(lat), 32'(LAT + 1));

        // SB then LB / LBU
        wr_cnt = 0;
        txn(0, 1'b1, 32'h21, 32'h00000080, 2'b00, 3'b000, lat);
        chk("sb_write_cycle", 32'(wr_cyc - t_start), 32'(LAT));
        chk("sb_write_count", 32'(wr_cnt), 32'd1);
        rd_cnt = 0;
        txn(0, 1'b0, 32'h21, 32'h0, 2'b00, 3'b000, lat);
        chk("lb_latency", 32'(lat), 32'(LAT + 1));
        chk("lb_read_cycles", 32'(rd_cnt), 32'(LAT));
        txn(0, 1'b0, 32'h21, 32'h0, 2'b00, 3'b011, lat);

        // Simultaneous requests after reset: C, D, C, D
        do_reset();
        order_q.delete();
        @(posedge clk);
        #1;
        fork
            begin
                int l0;
                txn(0, 1'b1, 32'h40, 32'h12345678, 2'b10, 3'b010, l0);
                txn(0, 1'b0, 32'h40, 32'h0, 2'b10, 3'b010, l0);
            end
            begin
                int l1;
                txn(1, 1'b1, 32'h140, 32'hA5A5A5A5, 2'b10, 3'b010, l1);
                txn(1, 1'b0, 32'h140, 32'h0, 2'b10, 3'b010, l1);
            end
        join
        chk("grant_count", 32'(order_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < order_q.size(); i++) begin
            chk($sformatf("grant_order_%0d", i), {31'd0, order_q[i]}, 32'(i % 2));
        end

        // Misaligned accesses
        wr_cnt = 0;
        txn(0, 1'b1, 32'h12, 32'h11111111, 2'b10, 3'b010, lat);
        chk("mis_sw_latency", 32'(lat), 32'd1);
        chk("mis_sw_no_write", 32'(wr_cnt), 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 2'b10, 3'b010, lat);
        txn(1, 1'b0, 32'h103, 32'h0, 2'b10, 3'b010, lat);
        chk("mis_lw_latency", 32'(lat), 32'd1);

        // Reset in the middle of a DMA store
        dma_we = 1'b1; dma_addr = 32'h120; dma_wdata = 32'hCAFEF00D; dma_req = 1'b1;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!mem_write && g < 50);
        chk("abort_reached_write", {31'd0, mem_write}, 32'd1);
        rst = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        #1;
        chk("abort_write_drops", {30'd0, mem_write, dma_done}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_no_write_edge", dword(9'h120), 32'd0);
        predict(1, 1'b1, 32'h120, 32'hCAFEF00D, 2'b10, 3'b010);
        rst = 1'b1;
        t_start = cyc;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!dma_done && g < 50);
        chk("reserve_latency", 32'(cyc - t_start), 32'(LAT + 1));
        @(posedge clk);
        #1 dma_req = 1'b0;
        chk("reserve_written", dword(9'h120), 32'hCAFEF00D);

        // Randomized concurrent traffic on disjoint regions
        fork
            begin
                int l2;
                repeat (60) begin
                    logic        we;
                    logic [1:0]  st;
                    logic [2:0]  lt;
                    logic [31:0] a;
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    we = 1'($urandom);
                    st = 2'($urandom_range(0, 2));
                    lt = 3'($urandom_range(0, 4));
                    a  = 32'($urandom_range(0, 255));
                    if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << size_of(we, st, lt)) - 1);
                    txn(0, we, a, $urandom, st, lt, l2);
                end
            end
            begin
                int l3;
                repeat (60) begin
                    logic        we;
                    logic [31:0] a;
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    we = 1'($urandom);
                    a  = 32'h100 + 32'($urandom_range(0, 255));
                    if ($urandom_range(0, 3) != 0) a = a & ~32'd3;
                    txn(1, we, a, $urandom, 2'b10, 3'b010, l3);
                end
            end
        join

        repeat (4) @(posedge clk);
        #1;
        chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
        chk("dma_queue_drained", 32'(dma_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
